// File: rtl/tdm_pkg.sv
// Shared constants for the word-interleaved TDM link.
// The mux transmitter uses the same frame geometry.
package tdm_pkg;

  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_RUN  = 1'b1
  } tdm_state_e;

  localparam int N_CH_DEF = 4;
  localparam int W_DEF    = 8;

endpackage

// File: rtl/tdm_lane_reg.sv
// One-entry holding register for a single demux output lane.
// A write wins over an ack in the same cycle, so the lane stays full with the new word.
module tdm_lane_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         ack,
  output logic [W-1:0] data,
  output logic         valid
);

  logic [W-1:0] data_q, data_d;
  logic         valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (wr_en) begin
      data_d  = wr_data;
      valid_d = 1'b1;
    end else if (ack) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data  = data_q;
  assign valid = valid_q;

endmodule

// File: rtl/tdm_demux.sv
// Time-division demultiplexer: steers word k of each SOF-tagged frame to lane k.
// Define TDM_DEMUX_ERR_CNT_EN to add a saturating err_cnt output counting sync_err pulses.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int N_CH = N_CH_DEF,
  parameter int W    = W_DEF,
  localparam int CW  = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      in_data,
  input  logic              in_sof,
  output logic [N_CH*W-1:0] out_data,
  output logic [N_CH-1:0]   out_valid,
  input  logic [N_CH-1:0]   out_ack,
  output logic              frame_done,
  output logic              sync_err
`ifdef TDM_DEMUX_ERR_CNT_EN
  ,
  output logic [15:0]       err_cnt
`endif
);

  tdm_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          frame_done_q, frame_done_d;
  logic          sync_err_q, sync_err_d;

  logic [CW-1:0] tgt;
  logic          xfer;
  logic [N_CH-1:0] wr_en;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    frame_done_d = 1'b0;
    sync_err_d   = 1'b0;
    wr_en        = '0;
    tgt          = '0;
    in_ready     = 1'b0;
    xfer         = 1'b0;

    if (state_q == ST_RUN && !in_sof) tgt = cnt_q;

    // In HUNT a non-SOF word is swallowed regardless of lane occupancy.
    if (state_q == ST_HUNT && !in_sof) in_ready = 1'b1;
    else                               in_ready = !out_valid[tgt] || out_ack[tgt];

    xfer = in_valid && in_ready;

    if (xfer) begin
      if (in_sof) begin
        wr_en[tgt] = 1'b1;
        state_d    = ST_RUN;
        cnt_d      = CW'(1);
        sync_err_d = (state_q == ST_RUN) && (cnt_q != '0);
      end else if (state_q == ST_RUN) begin
        if (cnt_q == '0) begin
          state_d    = ST_HUNT;
          sync_err_d = 1'b1;
        end else begin
          wr_en[tgt] = 1'b1;
          if (cnt_q == CW'(N_CH - 1)) begin
            cnt_d        = '0;
            frame_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_HUNT;
      cnt_q        <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
    end
  end

  assign frame_done = frame_done_q;
  assign sync_err   = sync_err_q;

  for (genvar k = 0; k < N_CH; k++) begin : g_lane
    tdm_lane_reg #(.W(W)) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en[k]),
      .wr_data (in_data),
      .ack     (out_ack[k]),
      .data    (out_data[k*W +: W]),
      .valid   (out_valid[k])
    );
  end

`ifdef TDM_DEMUX_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (sync_err_d && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule
